// File: rtl/foo_rr_arbiter_if.sv
// Point-to-point channel carrying a single payload field `a` from a source to a sink.
interface foo_intf #(
    parameter int W = 8
);
    logic [W-1:0] a;

    modport source (output a);
    modport sink   (input  a);
endinterface

// File: rtl/foo_rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters for up to HOLD cycles and
// muxes the granted requester's payload onto the shared downstream channel.
module foo_rr_arbiter #(
    parameter  int N    = 4,
    parameter  int HOLD = 2,
    parameter  int W    = 8,
    localparam int IW   = (N > 1) ? $clog2(N) : 1,
    localparam int CW   = $clog2(HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    foo_intf.sink         srcs [N-1:0],
    foo_intf.source       dst,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] pick;
    logic [IW-1:0] ptr_nxt;
    logic [N-1:0]  req_rot;
    logic          found;
    logic          any_req;
    logic          hold_on;
    logic [W-1:0]  a_arr [0:2**IW-1];

    // Payload table padded to a power of two so gnt_id always indexes in range.
    for (genvar i = 0; i < 2**IW; i++) begin : g_src
        if (i < N) begin : g_real
            assign a_arr[i] = srcs[i].a;
        end else begin : g_pad
            assign a_arr[i] = '0;
        end
    end

    assign dst.a = busy ? a_arr[gnt_id] : '0;

    // Rotate requests so position 0 is the current priority holder, then take the first set bit.
    always_comb begin
        any_req = |req;
        hold_on = (cnt != '0) && ((req & gnt) != '0);
        req_rot = N'({req, req} >> ptr);
        found   = 1'b0;
        pick    = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr) + k) % N);
            end
        end
        ptr_nxt = (int'(pick) == N - 1) ? '0 : pick + IW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= GRANT;
                        busy   <= 1'b1;
                        gnt    <= N'(1) << pick;
                        gnt_id <= pick;
                        cnt    <= CW'(HOLD - 1);
                        ptr    <= ptr_nxt;
                    end
                end
                GRANT: begin
                    if (hold_on) begin
                        cnt <= cnt - CW'(1);
                    end else if (any_req) begin
                        // Back-to-back handover: no idle bubble between grants.
                        gnt    <= N'(1) << pick;
                        gnt_id <= pick;
                        cnt    <= CW'(HOLD - 1);
                        ptr    <= ptr_nxt;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        gnt    <= '0;
                        gnt_id <= '0;
                        cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_foo_rr_arbiter.sv
// Bench for foo_rr_arbiter: a 4-requester HOLD=2 instance and a 1-requester HOLD=1
// instance, checked every cycle against a grant-ownership model plus fixed scenarios.
module tb_foo_rr_arbiter;
    localparam int N  = 4;
    localparam int HOLD = 2;
    localparam int IW = 2;
    localparam int EW = 1 + IW + N;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [IW-1:0] gnt_id;
    logic         busy;
    logic [7:0]   src_a [N];

    logic         req1;
    logic         gnt1;
    logic         gnt_id1;
    logic         busy1;
    logic [7:0]   src1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];
    logic [1:0]    exp1_q[$];

    foo_intf #(.W(8)) s_if [N-1:0] ();
    foo_intf #(.W(8)) d_if ();
    foo_intf #(.W(8)) s1_if [0:0] ();
    foo_intf #(.W(8)) d1_if ();

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign s_if[i].a = src_a[i];
    end
    assign s1_if[0].a = src1;

    foo_rr_arbiter #(.N(N), .HOLD(HOLD), .W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .srcs   (s_if),
        .dst    (d_if),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
    );

    foo_rr_arbiter #(.N(1), .HOLD(1), .W(8)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req1),
        .srcs   (s1_if),
        .dst    (d1_if),
        .gnt    (gnt1),
        .gnt_id (gnt_id1),
        .busy   (busy1)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Tracks who owns the channel and how many more cycles it may keep it.
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = 0;

    always @(posedge clk) begin : model
        logic [EW-1:0] e;
        if (!rst_n) begin
            m_owner = -1;
            m_left  = 0;
            m_ptr   = 0;
        end else if (m_owner >= 0 && m_left > 0 && req[m_owner]) begin
            m_left--;
        end else if (req != '0) begin
            int w;
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            m_owner = w;
            m_left  = HOLD - 1;
            m_ptr   = (w + 1) % N;
        end else begin
            m_owner = -1;
        end
        if (m_owner >= 0) e = {1'b1, IW'(m_owner), N'(1) << m_owner};
        else              e = '0;
        exp_q.push_back(e);
        exp1_q.push_back((rst_n && req1) ? 2'b11 : 2'b00);
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : compare
        logic [EW-1:0] e;
        logic [1:0]    e1;
        if (exp_q.size() == 0 || exp1_q.size() == 0) begin
            check("model_queue_empty", 0, 1);
        end else begin
            e  = exp_q.pop_front();
            e1 = exp1_q.pop_front();
            check("gnt",    gnt,    e[N-1:0]);
            check("gnt_id", gnt_id, e[N+IW-1:N]);
            check("busy",   busy,   e[EW-1]);
            check("dst_a",  d_if.a, e[EW-1] ? src_a[e[N+IW-1:N]] : 8'h00);
            check("onehot", $onehot0(gnt), 1);
            check("n1_gnt",  gnt1,    e1[0]);
            check("n1_busy", busy1,   e1[1]);
            check("n1_id",   gnt_id1, 0);
            check("n1_dst",  d1_if.a, e1[1] ? src1 : 8'h00);
        end
    end

    // ---------------- payload drivers ----------------
    initial begin
        src1 = 8'h00;
        for (int i = 0; i < N; i++) src_a[i] = 8'($urandom);
        forever begin
            @(posedge clk);
            #1;
            src1 = src1 + 8'h01;
            for (int i = 0; i < N; i++) src_a[i] = 8'($urandom);
        end
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [N-1:0] rot_gnt [6];
    int           rot_id  [6];
    logic [N-1:0] one;

    initial begin
        rot_gnt = '{4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0010, 4'b0010};
        rot_id  = '{1, 1, 3, 3, 1, 1};
        one     = 4'b0001;
        rst_n   = 1'b0;
        req     = 4'b1111;
        req1    = 1'b1;

        // reset values after two edges held in reset
        cycle();
        cycle();
        check("rst_gnt",  gnt,    0);
        check("rst_busy", busy,   0);
        check("rst_dst",  d_if.a, 0);
        #1 rst_n = 1'b1;
        cycle();
        check("rel_gnt",  gnt,  4'b0001);
        check("rel_n1",   gnt1, 1);

        // rotation with req=1010 from reset
        #1 rst_n = 1'b0; req = 4'b1010;
        cycle();
        #1 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("rot_gnt", gnt, rot_gnt[j]);
            check("rot_dst", d_if.a, src_a[rot_id[j]]);
        end

        // early release and re-grant
        #1 rst_n = 1'b0; req = 4'b0000;
        cycle();
        #1 rst_n = 1'b1; req = 4'b0100;
        cycle();
        check("er_gnt", gnt, 4'b0100);
        #1 req = 4'b0000;
        cycle();
        check("er_drop_gnt",  gnt,  0);
        check("er_drop_busy", busy, 0);
        #1 req = 4'b0100;
        cycle();
        check("er_regrant", gnt, 4'b0100);

        // full fairness with wrap-around
        #1 rst_n = 1'b0; req = 4'b0000;
        cycle();
        #1 rst_n = 1'b1; req = 4'b1111;
        for (int c = 0; c < 16; c++) begin
            cycle();
            check("fair_gnt", gnt, one << ((c / 2) % 4));
        end

        // reset during second cycle of requester 3's grant
        #1 rst_n = 1'b0; req = 4'b1001;
        cycle();
        check("midrst_gnt",  gnt,  0);
        check("midrst_busy", busy, 0);
        #1 rst_n = 1'b1;
        cycle();
        check("midrst_regrant", gnt, 4'b0001);

        // pointer must return to 0 on reset even when it had moved past requester 1
        #1 req = 4'b0010;
        cycle();
        check("ptr_pre_gnt", gnt, 4'b0010);
        #1 rst_n = 1'b0; req = 4'b1001;
        cycle();
        #1 rst_n = 1'b1;
        cycle();
        check("ptr_rst_gnt", gnt, 4'b0001);

        // randomized traffic, occasional resets and N=1 request drops
        for (int r = 0; r < 400; r++) begin
            #1;
            if ($urandom_range(0, 2) == 0) req = N'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 40) != 0);
            req1  = ($urandom_range(0, 4) != 0);
            cycle();
        end

        $display("*-* All Finished *-*");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/foo_rr_arbiter.md
# foo_rr_arbiter

Round-robin arbiter that shares one downstream `foo_intf` channel between an array of N upstream `foo_intf` requesters. Each requester raises a request bit; the arbiter grants exactly one requester at a time for a bounded burst of cycles and forwards that requester's `a` onto the shared source modport. It sits between a `foo_intf` interface array (sink side) and a single consumer, and provides the per-cycle ownership the fan-in datapath otherwise lacks.

## Interface
- `N`, default 4: number of requesters. Legal range is N ≥ 1, and N = 1 is a required-legal configuration.
- `HOLD`, default 2: maximum grant length in cycles. Legal range is HOLD ≥ 1.
- `IW`: localparam, `(N > 1) ? $clog2(N) : 1`.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `req`  input  N  per-requester request, sampled at the rising edge of `clk`.
- `srcs`  modport array  `foo_intf.sink srcs [N-1:0]`  upstream channels; only `srcs[i].a` is read.
- `dst`  modport  `foo_intf.source`  shared downstream channel; drives `dst.a`.
- `gnt`  output  N  one-hot grant (registered); all zeros when idle.
- `gnt_id`  output  IW  index of the granted requester (registered); holds 0 when idle.
- `busy`  output  1  high while in GRANT (registered).

## Operation
- State machine has two states, IDLE and GRANT, plus three registers: a rotating priority pointer `ptr` (IW bits), a hold counter `cnt` (width `$clog2(HOLD+1)`), and `gnt`/`gnt_id`.
- **Arbitration function.** Select the first `i` with `req[i]` = 1, searching `ptr, ptr+1, …, N-1, 0, …, ptr-1` with modulo-N wrap.
- **IDLE:**
  - If `|req` = 0, stay in IDLE.
  - Otherwise, go to GRANT. Load `gnt` = one-hot(i), `gnt_id` = i, `cnt` = HOLD-1, and `ptr` = (i+1) mod N.
- **GRANT, end condition.** The grant ends at the current edge if `cnt` = 0, or if `req[gnt_id]` = 0 (early release).
- **GRANT, grant continues.** Decrement `cnt`; leave `gnt`, `gnt_id` and `ptr` unchanged.
- **GRANT, grant ends.**
  - If `|req` = 1, re-arbitrate back-to-back with the updated `ptr` and stay in GRANT with no idle bubble.
  - If `|req` = 0, clear `gnt` and `gnt_id`, then go to IDLE.
- **Re-grant of the same requester.** Re-arbitration may select the same requester again only when it is the sole requester. Wrap-around from N-1 to 0 follows from the modulo pointer.
- **N = 1.** `ptr` stays 0. A continuously requesting requester 0 is re-granted every HOLD cycles with no gap.
- **Datapath.** `dst.a` = `srcs[gnt_id].a` when `busy` = 1, else 0. This path is combinational from `srcs[*].a`; the select is registered.
- **Reset.** While `rst_n` = 0 at an edge, the next state is IDLE with `ptr`=0, `cnt`=0, `gnt`=0, `gnt_id`=0, `busy`=0, so `dst.a`=0. Reset asserted mid-grant aborts the grant at that edge, with no completion.
- **Invariant.** `gnt` is one-hot or zero at all times.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled at edge k gives `gnt` valid after edge k.
- With `req` held continuously, a grant lasts exactly HOLD cycles. An early release shortens it: the grant drops at the edge that samples `req[gnt_id]` = 0.
- Between consecutive grants with pending requests the gap is 0 cycles.
- `dst.a` follows `srcs[gnt_id].a` in the same cycle, with zero latency.
- Fairness: with all N requesting, each requester receives HOLD cycles in every window of N·HOLD cycles.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 2 edges with `req`=4'b1111 → `gnt`=0, `busy`=0, `dst.a`=0. Release reset → after 1 edge `gnt`=4'b0001.
- **Rotation and pointer update.** N=4, HOLD=2; drive `req`=4'b1010 from reset.
  - Expected `gnt` sequence: 0010, 0010, 1000, 1000, 0010, 0010, …
  - `dst.a` tracks the corresponding `srcs[gnt_id].a` toggled by the bench.
- **Early release.** `req`=4'b0100 until `gnt`=0100, then drop `req[2]` for 1 cycle → `gnt`=0 and `busy`=0 after the next edge. Re-raise → re-grant after 1 edge.
- **Wrap-around and full fairness.** `req`=4'b1111 for 16 cycles → grant order 0,1,2,3,0,…, each for 2 cycles. `gnt` is never multi-hot (assertion on every cycle).
- **Reset mid-grant.** Assert `rst_n`=0 during the second cycle of a grant to requester 3 → next edge `gnt`=0 and `ptr`=0. Release with `req`=4'b1001 → `gnt`=0001.
- **N=1, HOLD=1.** Drive `req`=1 and increment `srcs[0].a` every cycle → `gnt`=1 continuously and `dst.a`==`srcs[0].a` on every cycle. `$fatal` on mismatch; print `*-* All Finished *-*`.
